// File: rtl/idct_sched.sv
// idct_sched: ping-pong coefficient buffering and burst scheduling in front
// of a pipelined IDCT datapath.
//
// A source streams 64 row-major coefficients per block into one of two
// 64x16 buffers. When a buffer is full, and fewer than MAX_INFLIGHT blocks
// are outstanding, the feeder plays it to the datapath as one contiguous
// 64-cycle burst. Tags returning from the datapath are counted to retire
// blocks.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   s_valid      source coefficient valid
//   s_ready      a coefficient can be accepted this cycle
//   s_data       signed coefficient
//   s_mode       block mode, sampled with coefficient 0 only
//   dp_start     one-cycle pulse with coefficient 0 of a burst
//   dp_x         coefficient driven to the datapath (0 outside bursts)
//   dp_idct      mode tag driven to the datapath (2'b00 = bubble)
//   dp_idct_out  tag returned by the datapath (nonzero = valid result)
//   blk_done     one-cycle pulse after the 64th returned result of a block
//   inflight     number of launched blocks not yet retired
//   busy         any buffer occupied or any block outstanding
//   err_mode     sticky: a block arrived with mode 2'b00
module idct_sched #(
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned GAP          = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [15:0] s_data,
  input  logic        [1:0]  s_mode,
  output logic               dp_start,
  output logic signed [15:0] dp_x,
  output logic        [1:0]  dp_idct,
  input  logic        [1:0]  dp_idct_out,
  output logic               blk_done,
  output logic        [2:0]  inflight,
  output logic               busy,
  output logic               err_mode
);

  localparam int unsigned DW    = 16;
  localparam int unsigned NCOEF = 64;
  localparam int unsigned CW    = 6;
  localparam int unsigned IW    = 3;
  localparam int unsigned GCW   = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0]  LAST     = CW'(NCOEF - 1);
  localparam logic [IW-1:0]  MAX_I    = IW'(MAX_INFLIGHT);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP - 1);
  localparam bit             NO_GAP   = (GAP == 0);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} buf_state_t;
  typedef enum logic [1:0] {F_IDLE, F_BURST, F_GAP} feed_state_t;

  logic signed [DW-1:0] mem [2][NCOEF];
  buf_state_t           bst [2];
  logic [1:0]           mode [2];

  logic                 wsel;
  logic                 rsel;
  logic [CW-1:0]        wcnt;
  logic [CW-1:0]        k;
  logic [CW-1:0]        rcnt;
  logic [GCW-1:0]       gcnt;
  feed_state_t          fstate;

  logic                 accept;
  logic                 fill_last;
  logic [1:0]           rdy;
  logic                 room;
  logic                 nrsel;
  logic                 burst_end;
  logic                 launch_idle;
  logic                 launch_b2b;
  logic                 launch;
  logic                 launch_sel;
  logic                 ret_valid;
  logic                 ret_last;
  logic                 inc;
  logic                 dec;

  // Source handshake: only the write-selected buffer can take data.
  assign s_ready   = (bst[wsel] == B_EMPTY) || (bst[wsel] == B_FILLING);
  assign accept    = s_valid && s_ready;
  assign fill_last = accept && (wcnt == LAST);

  // A buffer counts as ready in the cycle its last coefficient lands, so a
  // burst can start the very next cycle.
  assign rdy[0] = (bst[0] == B_FULL) || (fill_last && !wsel);
  assign rdy[1] = (bst[1] == B_FULL) || (fill_last &&  wsel);

  assign room        = inflight < MAX_I;
  assign nrsel       = ~rsel;
  assign burst_end   = (fstate == F_BURST) && (k == LAST);
  assign launch_idle = (fstate == F_IDLE) && rdy[rsel] && room;
  // Without a gap, the other buffer is launched straight out of the last
  // burst cycle so bursts abut.
  assign launch_b2b  = NO_GAP && burst_end && rdy[nrsel] && room;
  assign launch      = launch_idle || launch_b2b;
  assign launch_sel  = launch_b2b ? nrsel : rsel;

  assign ret_valid = (dp_idct_out != 2'b00);
  assign ret_last  = ret_valid && (rcnt == LAST);
  assign inc       = launch;
  // A retire with nothing outstanding is dropped rather than underflowing.
  assign dec       = ret_last && (inflight != '0);

  assign busy = (bst[0] != B_EMPTY) || (bst[1] != B_EMPTY) || (inflight != '0);

  // Coefficient storage; contents survive reset, state does not.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wsel][wcnt] <= s_data;
    end
  end

  // Buffer bookkeeping, feeder FSM, return counter and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bst[0]   <= B_EMPTY;
      bst[1]   <= B_EMPTY;
      mode[0]  <= 2'b00;
      mode[1]  <= 2'b00;
      wsel     <= 1'b0;
      rsel     <= 1'b0;
      wcnt     <= '0;
      k        <= '0;
      rcnt     <= '0;
      gcnt     <= '0;
      fstate   <= F_IDLE;
      dp_start <= 1'b0;
      dp_x     <= '0;
      dp_idct  <= 2'b00;
      blk_done <= 1'b0;
      inflight <= '0;
      err_mode <= 1'b0;
    end else begin
      // Write side
      if (accept) begin
        wcnt <= wcnt + CW'(1);
        if (wcnt == '0) begin
          bst[wsel]  <= B_FILLING;
          mode[wsel] <= (s_mode == 2'b00) ? 2'b01 : s_mode;
          if (s_mode == 2'b00) begin
            err_mode <= 1'b1;
          end
        end
        if (wcnt == LAST) begin
          bst[wsel] <= B_FULL;
          wsel      <= ~wsel;
        end
      end

      // Return side
      if (ret_valid) begin
        rcnt <= rcnt + CW'(1);
      end
      blk_done <= ret_last;
      if (inc && !dec) begin
        inflight <= inflight + IW'(1);
      end else if (!inc && dec) begin
        inflight <= inflight - IW'(1);
      end

      // Feeder
      dp_start <= 1'b0;
      dp_x     <= '0;
      dp_idct  <= 2'b00;
      case (fstate)
        F_IDLE: begin
        end
        F_BURST: begin
          if (!burst_end) begin
            k       <= k + CW'(1);
            dp_x    <= mem[rsel][k + CW'(1)];
            dp_idct <= mode[rsel];
          end else begin
            bst[rsel] <= B_EMPTY;
            rsel      <= nrsel;
            fstate    <= NO_GAP ? F_IDLE : F_GAP;
            gcnt      <= '0;
          end
        end
        F_GAP: begin
          if (gcnt == GAP_LAST) begin
            fstate <= F_IDLE;
          end else begin
            gcnt <= gcnt + GCW'(1);
          end
        end
        default: fstate <= F_IDLE;
      endcase

      // Launch overrides the burst-end transition and the FULL marking of a
      // buffer completed this cycle.
      if (launch) begin
        fstate          <= F_BURST;
        k               <= '0;
        bst[launch_sel] <= B_DRAINING;
        dp_start        <= 1'b1;
        dp_x            <= mem[launch_sel][0];
        dp_idct         <= mode[launch_sel];
      end
    end
  end

endmodule

// File: tb/tb_idct_sched.sv
// Directed bench for idct_sched. Two instances share clock, reset and source
// stimulus: dut uses MAX_INFLIGHT=2 with a 20-cycle return path, dut1 uses
// MAX_INFLIGHT=1 with a 100-cycle return path. Each scenario lists, per
// block, the fill start, the hand-derived burst start and the retire cycle.
module tb_idct_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid;
  logic [15:0] s_data;
  logic [1:0]  s_mode;

  logic        s_ready0, dp_start0, blk_done0, busy0, err0;
  logic [15:0] dp_x0;
  logic [1:0]  dp_idct0, dp_idct_out0;
  logic [2:0]  inflight0;

  logic        s_ready1, dp_start1, blk_done1, busy1, err1;
  logic [15:0] dp_x1;
  logic [1:0]  dp_idct1, dp_idct_out1;
  logic [2:0]  inflight1;

  int checks   = 0;
  int failures = 0;

  // Scenario description
  int          nb;
  int          sel;
  int          scale;
  int          fs [4];
  int          lt [4];
  int          dt [4];
  logic [1:0]  md [4];

  always #5 clk = ~clk;

  idct_sched #(.MAX_INFLIGHT(2), .GAP(0)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0),
    .s_data(s_data), .s_mode(s_mode), .dp_start(dp_start0), .dp_x(dp_x0),
    .dp_idct(dp_idct0), .dp_idct_out(dp_idct_out0), .blk_done(blk_done0),
    .inflight(inflight0), .busy(busy0), .err_mode(err0)
  );

  idct_sched #(.MAX_INFLIGHT(1), .GAP(0)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .s_mode(s_mode), .dp_start(dp_start1), .dp_x(dp_x1),
    .dp_idct(dp_idct1), .dp_idct_out(dp_idct_out1), .blk_done(blk_done1),
    .inflight(inflight1), .busy(busy1), .err_mode(err1)
  );

  // Datapath stand-in: tags come back after a fixed latency.
  logic [1:0] pipe0 [128];
  logic [1:0] pipe1 [128];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) begin
        pipe0[i] <= 2'b00;
        pipe1[i] <= 2'b00;
      end
    end else begin
      pipe0[0] <= dp_idct0;
      pipe1[0] <= dp_idct1;
      for (int i = 1; i < 128; i++) begin
        pipe0[i] <= pipe0[i-1];
        pipe1[i] <= pipe1[i-1];
      end
    end
  end

  assign dp_idct_out0 = pipe0[19];
  assign dp_idct_out1 = pipe1[99];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, ".s_ready"},  32'(s_ready0),  32'd1);
    check({tag, ".dp_start"}, 32'(dp_start0), 32'd0);
    check({tag, ".dp_x"},     32'(dp_x0),     32'd0);
    check({tag, ".dp_idct"},  32'(dp_idct0),  32'd0);
    check({tag, ".blk_done"}, 32'(blk_done0), 32'd0);
    check({tag, ".inflight"}, 32'(inflight0), 32'd0);
    check({tag, ".busy"},     32'(busy0),     32'd0);
    check({tag, ".err_mode"}, 32'(err0),      32'd0);
    check({tag, ".inflight1"}, 32'(inflight1), 32'd0);
    check({tag, ".busy1"},     32'(busy1),     32'd0);
  endtask

  task automatic do_reset(input string tag);
    s_valid = 1'b0;
    s_data  = '0;
    s_mode  = 2'b00;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset(tag);
  endtask

  // Drive the scenario for T cycles and compare every cycle against the
  // listed schedule.
  task automatic run(input string name, input int T);
    logic [15:0] ex_x, o_x;
    logic [1:0]  ex_tag, o_tag;
    logic        ex_start, ex_done, ex_err, o_start, o_done, o_err, o_rdy;
    int          ex_inf;
    logic [2:0]  o_inf;
    for (int t = 0; t < T; t++) begin
      s_valid = 1'b0;
      s_data  = '0;
      s_mode  = 2'b00;
      ex_x = '0; ex_tag = 2'b00; ex_start = 1'b0; ex_done = 1'b0; ex_err = 1'b0;
      ex_inf = 0;
      for (int b = 0; b < nb; b++) begin
        if (t >= fs[b] && t < fs[b] + 64) begin
          s_valid = 1'b1;
          s_data  = 16'((b * 64 + t - fs[b] + 1) * scale);
          s_mode  = md[b];
        end
        if (t >= lt[b] && t < lt[b] + 64) begin
          ex_x     = 16'((b * 64 + t - lt[b] + 1) * scale);
          ex_tag   = (md[b] == 2'b00) ? 2'b01 : md[b];
          ex_start = (t == lt[b]);
        end
        if (t >= lt[b]) ex_inf++;
        if (t >= dt[b]) ex_inf--;
        if (t == dt[b]) ex_done = 1'b1;
        if (md[b] == 2'b00 && t > fs[b]) ex_err = 1'b1;
      end
      if (sel == 0) begin
        o_x = dp_x0; o_tag = dp_idct0; o_start = dp_start0; o_done = blk_done0;
        o_err = err0; o_rdy = s_ready0; o_inf = inflight0;
      end else begin
        o_x = dp_x1; o_tag = dp_idct1; o_start = dp_start1; o_done = blk_done1;
        o_err = err1; o_rdy = s_ready1; o_inf = inflight1;
      end
      check($sformatf("%s.dp_x@%0d", name, t),     32'(o_x),     32'(ex_x));
      check($sformatf("%s.dp_idct@%0d", name, t),  32'(o_tag),   32'(ex_tag));
      check($sformatf("%s.dp_start@%0d", name, t), 32'(o_start), 32'(ex_start));
      check($sformatf("%s.inflight@%0d", name, t), 32'(o_inf),   32'(ex_inf));
      check($sformatf("%s.blk_done@%0d", name, t), 32'(o_done),  32'(ex_done));
      check($sformatf("%s.err_mode@%0d", name, t), 32'(o_err),   32'(ex_err));
      if (s_valid) begin
        check($sformatf("%s.s_ready@%0d", name, t), 32'(o_rdy), 32'd1);
      end
      tick();
    end
    s_valid = 1'b0;
    s_data  = '0;
    s_mode  = 2'b00;
  endtask

  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    s_mode  = 2'b00;
    sel     = 0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset("por");

    // Single block 1..64, mode 10: burst right after the last acceptance.
    nb = 1; scale = 1;
    fs[0] = 0; lt[0] = 64; dt[0] = 148; md[0] = 2'b10;
    run("one", 160);
    check("one.busy_idle", 32'(busy0), 32'd0);
    check("one.s_ready_idle", 32'(s_ready0), 32'd1);
    do_reset("rst_a");

    // Three back-to-back blocks: bursts abut, source never stalls.
    nb = 3; scale = 523;
    fs[0] = 0;   lt[0] = 64;  dt[0] = 148; md[0] = 2'b01;
    fs[1] = 64;  lt[1] = 128; dt[1] = 212; md[1] = 2'b10;
    fs[2] = 128; lt[2] = 192; dt[2] = 276; md[2] = 2'b11;
    run("b2b", 290);
    do_reset("rst_b");

    // Block 1 launch coincides with block 0 retire (t=148); block 1 has
    // mode 00, and err_mode must survive block 2.
    nb = 3; scale = -7;
    fs[0] = 0;   lt[0] = 64;  dt[0] = 148; md[0] = 2'b11;
    fs[1] = 84;  lt[1] = 148; dt[1] = 232; md[1] = 2'b00;
    fs[2] = 148; lt[2] = 212; dt[2] = 296; md[2] = 2'b01;
    run("coin", 310);
    check("coin.err_sticky", 32'(err0), 32'd1);
    do_reset("rst_c");

    // MAX_INFLIGHT=1, 100-cycle return: second burst waits for blk_done.
    sel = 1; nb = 2; scale = 3;
    fs[0] = 0;  lt[0] = 64;  dt[0] = 228; md[0] = 2'b10;
    fs[1] = 64; lt[1] = 229; dt[1] = 393; md[1] = 2'b11;
    run("mx1", 400);
    sel = 0;
    do_reset("rst_d");

    // Reset at coefficient 30 of a fill discards the partial block.
    nb = 1; scale = 3;
    fs[0] = 0; lt[0] = 1000; dt[0] = 1000; md[0] = 2'b01;
    run("pfill", 30);
    s_valid = 1'b1;
    s_data  = 16'd93;
    s_mode  = 2'b01;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    s_valid = 1'b0;
    chk_reset("rst_fill");
    nb = 1; scale = -5;
    fs[0] = 0; lt[0] = 64; dt[0] = 148; md[0] = 2'b11;
    run("afill", 160);

    // Reset at k=10 of a burst.
    nb = 1; scale = 9;
    fs[0] = 0; lt[0] = 64; dt[0] = 148; md[0] = 2'b11;
    run("pburst", 74);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_burst");
    nb = 1; scale = 11;
    fs[0] = 0; lt[0] = 64; dt[0] = 148; md[0] = 2'b10;
    run("aburst", 160);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idct_sched.md
IDCT_SCHED -- requirements
Module: idct_sched

Interface
REQ-001 Parameter MAX_INFLIGHT, default 2: maximum number of blocks launched into the datapath whose 64 results have not yet returned.
REQ-002 Parameter GAP, default 0: minimum number of idle cycles between consecutive datapath bursts.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 s_valid  input  1  source coefficient valid.
REQ-006 s_ready  output  1  scheduler can accept a coefficient.
REQ-007 s_data  input  16  signed coefficient, row-major order, 64 per block.
REQ-008 s_mode  input  2  block mode, sampled only with coefficient 0 of each block.
REQ-009 dp_start  output  1  one-cycle pulse that marks coefficient 0 of a burst.
REQ-010 dp_x  output  16  signed coefficient driven to the datapath.
REQ-011 dp_idct  output  2  mode tag driven to the datapath; 2'b00 means bubble.
REQ-012 dp_idct_out  input  2  tag returned from the datapath; nonzero means a valid result.
REQ-013 blk_done  output  1  one-cycle pulse on the 64th valid returned result.
REQ-014 inflight  output  3  count of outstanding blocks.
REQ-015 busy  output  1  high if any buffer is non-empty or inflight is nonzero.
REQ-016 err_mode  output  1  sticky flag: a block arrived with mode 2'b00.

Function
REQ-017 Storage SHALL be two 64x16 ping-pong buffers, each with a 2-bit mode register and state EMPTY, FILLING, FULL or DRAINING.
REQ-018 A source transfer SHALL occur when s_valid and s_ready are both high; s_ready SHALL be high iff the write-selected buffer is EMPTY or FILLING.
REQ-019 A write counter 0..63 SHALL address the buffer; coefficient 0 sets the buffer to FILLING and captures s_mode; coefficient 63 sets it to FULL and toggles write select.
REQ-020 s_mode 2'b00 on coefficient 0 SHALL be stored as 2'b01 and SHALL set err_mode; err_mode clears only on reset.
REQ-021 Feeder FSM states: IDLE, BURST, GAP.
REQ-022 IDLE -> BURST when the read-selected buffer is FULL and inflight < MAX_INFLIGHT; the earliest BURST cycle is the cycle after coefficient 63 is accepted.
REQ-023 In BURST, the feeder SHALL drive 64 contiguous cycles of dp_x = buffer[k] and dp_idct = stored mode, with k = 0..63, and dp_start high only when k = 0; the buffer SHALL be DRAINING during the burst.
REQ-024 On k = 63: the buffer SHALL become EMPTY on the next cycle and read select SHALL toggle; the FSM SHALL go to GAP if GAP > 0, else to IDLE. With GAP = 0, a second FULL buffer SHALL start its burst one cycle after k = 63.
REQ-025 GAP SHALL last exactly GAP cycles, then return to IDLE.
REQ-026 Outside BURST, dp_x SHALL be 0, dp_idct 2'b00 and dp_start 0.
REQ-027 inflight SHALL increment on dp_start and decrement on blk_done; when both occur in the same cycle it SHALL be unchanged.
REQ-028 A return counter 0..63 SHALL advance on each cycle with dp_idct_out != 0; at count 63 it SHALL pulse blk_done and wrap to 0.
REQ-029 blk_done while inflight = 0 SHALL be ignored for the inflight count and SHALL NOT underflow it.
REQ-030 A source write to a buffer and a feeder read of the other buffer SHALL proceed concurrently without stalls.

Reset
REQ-031 On rst: both buffers EMPTY, write/read select 0, all counters 0, FSM IDLE.
REQ-032 On rst, outputs SHALL be s_ready=1, dp_start=0, dp_x=0, dp_idct=0, blk_done=0, inflight=0, busy=0, err_mode=0.
REQ-033 Reset asserted mid-fill or mid-burst SHALL discard all partial data; buffer contents need not be cleared.

Verification
REQ-034 One block, coefficients 1..64, mode 2'b10, s_valid always high -> dp_start one cycle after the 64th acceptance, dp_x = 1..64 contiguous, dp_idct = 2'b10 for 64 cycles.
REQ-035 Three back-to-back blocks with GAP=0 and results returned after 20 cycles -> bursts adjacent; s_ready low only while both buffers are FULL or DRAINING.
REQ-036 MAX_INFLIGHT=1 with results delayed 100 cycles -> second burst starts the cycle after blk_done; inflight never exceeds 1.
REQ-037 Block with s_mode=2'b00 -> err_mode=1, burst dp_idct=2'b01, err_mode persists across later blocks until rst.
REQ-038 rst pulsed at coefficient 30 of a fill and at k=10 of a burst -> all outputs return to reset values next cycle; the next full block is processed correctly.
REQ-039 dp_start and blk_done coincident -> inflight unchanged that cycle.
